// File: rtl/layer_mixer.sv
// Fixed-priority layer mixer: layer 0 on top, frame-shadowed layer enables,
// two-cycle registered RGB path and per-frame collision report against layer 0.
module layer_mixer #(
    parameter int NUM_LAYERS = 8,
    parameter int COLOR_W    = 8,
    parameter int SEL_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_v_sync,
    input  logic                            i_de,
    input  logic [NUM_LAYERS-1:0]           i_layer_hit,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] i_layer_rgb,
    input  logic [3*COLOR_W-1:0]            i_bg_rgb,
    input  logic [NUM_LAYERS-1:0]           i_layer_en,
    output logic [COLOR_W-1:0]              o_red,
    output logic [COLOR_W-1:0]              o_green,
    output logic [COLOR_W-1:0]              o_blue,
    output logic                            o_de,
    output logic [SEL_W-1:0]                o_top_layer,
    output logic [NUM_LAYERS-1:0]           o_collide,
    output logic                            o_collide_valid
);

    localparam logic [SEL_W-1:0]      SEL_BG   = SEL_W'(NUM_LAYERS);
    localparam logic [NUM_LAYERS-1:0] REF_BIT  = NUM_LAYERS'(1);

    logic                    vs_d;
    logic                    vs_edge;
    logic [NUM_LAYERS-1:0]   active_mask;
    logic [NUM_LAYERS-1:0]   eff;
    logic [NUM_LAYERS-1:0]   cur;
    logic [NUM_LAYERS-1:0]   acc;

    logic [SEL_W-1:0]        win_sel;
    logic [3*COLOR_W-1:0]    win_rgb;

    logic [SEL_W-1:0]        sel_p1;
    logic [3*COLOR_W-1:0]    win_rgb_p1;
    logic [3*COLOR_W-1:0]    bg_p1;
    logic                    vld_p1;

    logic [3*COLOR_W-1:0]    rgb_p2;
    logic [SEL_W-1:0]        sel_p2;
    logic                    vld_p2;

    assign vs_edge = i_v_sync & ~vs_d;
    // The mask used here is the one held before any edge update this cycle.
    assign eff     = i_layer_hit & active_mask & {NUM_LAYERS{i_de}};
    assign cur     = eff[0] ? (eff & ~REF_BIT) : '0;

    always_comb begin
        win_sel = SEL_BG;
        win_rgb = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (eff[k]) begin
                win_sel = SEL_W'(k);
                win_rgb = i_layer_rgb[k*3*COLOR_W +: 3*COLOR_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_d            <= 1'b1;
            active_mask     <= '1;
            acc             <= '0;
            o_collide       <= '0;
            o_collide_valid <= 1'b0;
        end else begin
            vs_d <= i_v_sync;
            if (vs_edge) begin
                active_mask     <= i_layer_en;
                o_collide       <= acc | cur;
                acc             <= '0;
                o_collide_valid <= 1'b1;
            end else begin
                acc             <= acc | cur;
                o_collide_valid <= 1'b0;
            end
        end
    end

    // Stage 1: priority-encoded winner
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_p1     <= SEL_BG;
            win_rgb_p1 <= '0;
            bg_p1      <= '0;
            vld_p1     <= 1'b0;
        end else begin
            sel_p1     <= win_sel;
            win_rgb_p1 <= win_rgb;
            bg_p1      <= i_bg_rgb;
            vld_p1     <= i_de;
        end
    end

    // Stage 2: final colour select, blanked outside active video
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_p2 <= '0;
            sel_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                rgb_p2 <= (sel_p1 != SEL_BG) ? win_rgb_p1 : bg_p1;
                sel_p2 <= sel_p1;
            end else begin
                rgb_p2 <= '0;
                sel_p2 <= SEL_BG;
            end
        end
    end

    assign o_red       = rgb_p2[3*COLOR_W-1:2*COLOR_W];
    assign o_green     = rgb_p2[2*COLOR_W-1:COLOR_W];
    assign o_blue      = rgb_p2[COLOR_W-1:0];
    assign o_de        = vld_p2;
    assign o_top_layer = sel_p2;

endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer with four layers: priority, blanking,
// enable shadowing, collision reporting and mid-frame reset.
module tb_layer_mixer;

    localparam int NL = 4;
    localparam int CW = 8;
    localparam int SW = $clog2(NL + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              v_sync;
    logic              de;
    logic [NL-1:0]     layer_hit;
    logic [NL*3*CW-1:0] layer_rgb;
    logic [3*CW-1:0]   bg_rgb;
    logic [NL-1:0]     layer_en;
    logic [CW-1:0]     red, green, blue;
    logic              de_out;
    logic [SW-1:0]     top_layer;
    logic [NL-1:0]     collide;
    logic              collide_valid;

    int n_checks = 0;
    int n_fail   = 0;

    layer_mixer #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_v_sync        (v_sync),
        .i_de            (de),
        .i_layer_hit     (layer_hit),
        .i_layer_rgb     (layer_rgb),
        .i_bg_rgb        (bg_rgb),
        .i_layer_en      (layer_en),
        .o_red           (red),
        .o_green         (green),
        .o_blue          (blue),
        .o_de            (de_out),
        .o_top_layer     (top_layer),
        .o_collide       (collide),
        .o_collide_valid (collide_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rgb_now();
        return {8'h00, red, green, blue};
    endfunction

    initial begin
        rst_n     = 1'b0;
        v_sync    = 1'b0;
        de        = 1'b0;
        layer_hit = '0;
        layer_rgb = {24'h445566, 24'h00FF00, 24'h112233, 24'hFF0000};
        bg_rgb    = 24'h000080;
        layer_en  = 4'b1111;
        #1;
        chk("rst_rgb", rgb_now(), 32'h0);
        chk("rst_top", 32'(top_layer), 32'd0);
        chk("rst_de", 32'(de_out), 32'd0);
        step(); step();
        chk("rst_collide", 32'(collide), 32'd0);
        chk("rst_cvalid", 32'(collide_valid), 32'd0);
        rst_n = 1'b1;
        step();

        // Priority: layer 1 beats layer 3
        de = 1'b1; layer_hit = 4'b1010;
        step(); step();
        chk("prio_rgb", rgb_now(), 32'h112233);
        chk("prio_top", 32'(top_layer), 32'd1);
        chk("prio_de", 32'(de_out), 32'd1);

        layer_hit = 4'b0000;
        step(); step();
        chk("bg_rgb", rgb_now(), 32'h000080);
        chk("bg_top", 32'(top_layer), 32'd4);

        de = 1'b0; layer_hit = 4'b0001;
        step(); step();
        chk("blank_rgb", rgb_now(), 32'h0);
        chk("blank_top", 32'(top_layer), 32'd4);
        chk("blank_de", 32'(de_out), 32'd0);

        // Enable shadowing: mid-frame change ignored until the v_sync rise
        de = 1'b1; layer_en = 4'b1101; layer_hit = 4'b0010;
        step(); step();
        chk("shadow_mid_top", 32'(top_layer), 32'd1);
        v_sync = 1'b1;
        step();
        chk("edge0_cvalid", 32'(collide_valid), 32'd1);
        chk("edge0_collide", 32'(collide), 32'd0);
        step();
        chk("edge0_cvalid_drop", 32'(collide_valid), 32'd0);
        chk("shadow_edgepix_top", 32'(top_layer), 32'd1);
        step();
        chk("shadow_after_top", 32'(top_layer), 32'd4);
        chk("shadow_after_rgb", rgb_now(), 32'h000080);

        // Restore all enables at the next frame boundary
        v_sync = 1'b0; layer_en = 4'b1111; layer_hit = 4'b0000;
        step();
        v_sync = 1'b1;
        step();
        v_sync = 1'b0;

        // Collision frame: 0101 x3, 0011 x1
        layer_hit = 4'b0101;
        step(); step(); step();
        layer_hit = 4'b0011;
        step();
        layer_hit = 4'b0000;
        step();
        chk("no_early_cvalid", 32'(collide_valid), 32'd0);
        v_sync = 1'b1;
        step();
        chk("coll_collide", 32'(collide), 32'b0110);
        chk("coll_cvalid", 32'(collide_valid), 32'd1);
        v_sync = 1'b0;
        step();
        chk("coll_cvalid_1cyc", 32'(collide_valid), 32'd0);
        chk("coll_hold", 32'(collide), 32'b0110);
        step(); step();
        v_sync = 1'b1;
        step();
        chk("clean_collide", 32'(collide), 32'd0);
        chk("clean_cvalid", 32'(collide_valid), 32'd1);

        // Collision pixel on the edge cycle belongs to the closing frame
        v_sync = 1'b0;
        step();
        v_sync = 1'b1; layer_hit = 4'b1001;
        step();
        chk("edgepix_collide", 32'(collide), 32'b1000);
        chk("edgepix_cvalid", 32'(collide_valid), 32'd1);
        v_sync = 1'b0; layer_hit = 4'b0000;
        step(); step();
        v_sync = 1'b1;
        step();
        chk("newframe_collide", 32'(collide), 32'd0);

        // Reset mid-frame with collisions pending and v_sync held high
        v_sync = 1'b0;
        step();
        layer_hit = 4'b0101;
        step(); step();
        layer_en = 4'b0001;
        v_sync = 1'b1; layer_hit = 4'b0000; rst_n = 1'b0;
        #1;
        chk("mrst_rgb", rgb_now(), 32'h0);
        chk("mrst_de", 32'(de_out), 32'd0);
        chk("mrst_collide", 32'(collide), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("mrst_no_pulse", 32'(collide_valid), 32'd0);
        layer_hit = 4'b1000;
        step();
        chk("mrst_no_pulse2", 32'(collide_valid), 32'd0);
        step();
        chk("mrst_mask_top", 32'(top_layer), 32'd3);
        chk("mrst_mask_rgb", rgb_now(), 32'h445566);
        v_sync = 1'b0; layer_hit = 4'b0000;
        step();
        v_sync = 1'b1;
        step();
        chk("mrst_acc_cleared", 32'(collide), 32'd0);
        chk("mrst_edge_cvalid", 32'(collide_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
Parametrised, pipelined successor to the fixed priority layer mux in the graphics top. It merges NUM_LAYERS sprite/overlay layers over a background with fixed index priority (layer 0 highest) and per-layer enables that are shadowed to frame boundaries. It registers RGB output with fixed latency and accumulates per-frame collisions between layer 0 (player sprite) and every other layer, reporting them once per v_sync. It sits between the layer compositors and the video output stage, and feeds collision results to the game FSM.

Parameters:
NUM_LAYERS, 8, number of overlay layers (legal 2..32); index 0 = highest priority and collision reference layer
COLOR_W, 8, bits per colour channel
SEL_W, $clog2(NUM_LAYERS+1), width of o_top_layer (derived; do not override)

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_v_sync  in  1  vertical sync; rising edge = frame boundary
i_de  in  1  pixel valid (active video) for this cycle's inputs
i_layer_hit  in  NUM_LAYERS  per-layer opaque-pixel flag; bit k = layer k
i_layer_rgb  in  NUM_LAYERS*3*COLOR_W  layer k colour at bits [k*3*COLOR_W +: 3*COLOR_W], packed {R,G,B}
i_bg_rgb  in  3*COLOR_W  background colour {R,G,B}
i_layer_en  in  NUM_LAYERS  requested layer enable mask (shadowed)
o_red / o_green / o_blue  out  COLOR_W each  mixed pixel colour
o_de  out  1  i_de delayed to align with RGB
o_top_layer  out  SEL_W  index of winning layer; NUM_LAYERS when background shown
o_collide  out  NUM_LAYERS  layers that overlapped layer 0 during the last completed frame; bit 0 always 0
o_collide_valid  out  1  one-cycle strobe when o_collide updates

Behaviour:
- Reset (async assert, sync release): all outputs 0; active enable mask = all ones; collision accumulator = 0; v_sync delay register = 1, so a high v_sync at reset release gives no false edge.
- Frame edge: vs_edge = i_v_sync & ~vs_d, where vs_d is i_v_sync registered.
- Enable shadow: on the vs_edge cycle, active mask <= i_layer_en. Mid-frame changes to i_layer_en have no effect until the next edge.
- Effective hit: eff = i_layer_hit & active_mask & {NUM_LAYERS{i_de}}. Uses the mask value held before the edge's update.
- Stage 1 (register): priority-encode eff, lowest set index wins. Register the winner index (NUM_LAYERS if none), the winner RGB, i_bg_rgb and i_de.
- Stage 2 (register): RGB = winner RGB if a layer won, else bg RGB. When the stage-1 de is 0, RGB = 0 and o_top_layer = NUM_LAYERS. o_de = stage-1 de.
- Latency: exactly 2 cycles from inputs to o_red/o_green/o_blue, o_de and o_top_layer. Throughput 1 pixel per cycle, no stalls.
- Collision: cur = eff[0] ? (eff & ~1) : 0. Each non-edge cycle: acc <= acc | cur.
- On the vs_edge cycle: o_collide <= acc | cur; acc <= 0; o_collide_valid <= 1 for that single following cycle. o_collide then holds until the next edge.
- Disabled layers (mask bit 0) neither display nor collide. If layer 0 is disabled, no collisions are recorded.
- Simultaneous events: a vs_edge coinciding with a collision pixel counts toward the closing frame, never the new one.
- Reset mid-frame: pipeline contents, acc and o_collide are discarded, and the mask returns to all ones.

Test Plan:
- NUM_LAYERS=4, reset, no v_sync, i_de=1, hit=4'b1010, layer1 rgb=0x112233, layer3 rgb=0x445566, bg=0x000080 -> 2 cycles later RGB=0x112233, o_top_layer=1, o_de=1.
- Same setup with hit=0 -> RGB=0x000080, o_top_layer=4. Then i_de=0 with hit=4'b0001 -> RGB=0, o_top_layer=4, o_de=0.
- Change i_layer_en to 4'b1101 mid-frame with hit=4'b0010 -> layer 1 is still shown until the v_sync rise. After the rise -> background shown, o_top_layer=4.
- Frame with hit=4'b0101 for 3 cycles and 4'b0011 for 1 cycle, then v_sync rise -> o_collide=4'b0110 with o_collide_valid high exactly 1 cycle. Next clean frame -> o_collide=0 at its edge.
- Collision pixel (hit=4'b1001) applied on the exact vs_edge cycle -> o_collide bit3=1 for the closing frame. Accumulator for the new frame = 0.
- Assert i_rst_n low mid-frame with accumulated collisions and v_sync held high through release -> all outputs 0, no o_collide_valid pulse, mask=4'b1111.
